// File: rtl/reg_share_pkg.sv
// reg_share_pkg: shared types and default sizes for the register-share arbiter.
//   reg_share_state_t     - sequencer state encoding (IDLE, WRITE, SETTLE, RESPOND)
//   REG_SHARE_N_REQ_DEF   - default requester count
//   REG_SHARE_WIDTH_DEF   - default register bank width
package reg_share_pkg;

  localparam int REG_SHARE_N_REQ_DEF = 4;
  localparam int REG_SHARE_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_RESPOND = 2'd3
  } reg_share_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  [N_REQ]          request vector
//   ptr  [clog2(N_REQ)]   index of the last served requester; search starts at ptr+1
//   gnt  [N_REQ]          one-hot grant (all zero when nothing requests)
//   idx  [clog2(N_REQ)]   binary index of the granted requester
//   hit                   at least one request present
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int N_REQ = REG_SHARE_N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     hit
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] cand_s;
  logic          take_s;

  // Index that lies 'step' places after 'base', wrapping at N_REQ-1.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int step);
    int sum;
    sum = (int'(base) + step) % N_REQ;
    return IW'(sum);
  endfunction

  // Walk candidates ptr+1 .. ptr+N_REQ (ptr itself last) and keep the first hit.
  always_comb begin
    gnt    = {N_REQ{1'b0}};
    idx    = {IW{1'b0}};
    hit    = 1'b0;
    cand_s = {IW{1'b0}};
    take_s = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s      = wrap_idx(ptr, k);
      take_s      = !hit && req[cand_s];
      gnt[cand_s] = gnt[cand_s] | take_s;
      idx         = take_s ? cand_s : idx;
      hit         = hit | take_s;
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: shares one external WIDTH-bit d_ff bank between N_REQ
// requesters. One write is accepted at a time, pushed into the bank, read back
// and returned to its requester with a mismatch flag.
//   clk, rst (sync, active-low)
//   req_valid/req_data  per-requester write requests (slice i = [i*WIDTH +: WIDTH])
//   req_lock            per-requester lock request (only with REG_SHARE_LOCK_EN)
//   req_ready           one-hot accept strobe (combinational, IDLE only)
//   d_out/d_we          data and capture enable to the bank
//   q_in                bank output
//   rd_data/rd_valid/rd_id/err  readback result, strobe, owner, mismatch
//   busy                sequencer not in IDLE
// Optional feature macro: REG_SHARE_LOCK_EN (requester lock / burst ownership).
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N_REQ = REG_SHARE_N_REQ_DEF,
  parameter int WIDTH = REG_SHARE_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
`ifdef REG_SHARE_LOCK_EN
  input  logic [N_REQ-1:0]         req_lock,
`endif
  output logic [N_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]         d_out,
  output logic                     d_we,
  input  logic [WIDTH-1:0]         q_in,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(N_REQ)-1:0] rd_id,
  output logic                     err,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);

  reg_share_state_t state_r;
  reg_share_state_t state_nxt_s;

  logic [WIDTH-1:0] data_r;
  logic [IW-1:0]    id_r;
  logic [IW-1:0]    ptr_r;

  logic [N_REQ-1:0] pick_req_s;
  logic [N_REQ-1:0] pick_gnt_s;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_hit_s;
  logic             accept_s;

`ifdef REG_SHARE_LOCK_EN
  logic lock_r;
  logic lock_hold_s;

  // A held lock narrows the candidate set to the previous owner only.
  assign lock_hold_s = lock_r & req_valid[id_r] & req_lock[id_r];
  assign pick_req_s  = lock_hold_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << id_r) : req_valid;
`else
  assign pick_req_s  = req_valid;
`endif

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req (pick_req_s),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .hit (pick_hit_s)
  );

  // Gating with rst keeps req_ready low while reset is asserted, since that grant would be discarded.
  assign accept_s  = (state_r == ST_IDLE) && pick_hit_s && rst;
  assign req_ready = accept_s ? pick_gnt_s : {N_REQ{1'b0}};

  assign d_we     = (state_r == ST_WRITE);
  assign d_out    = ((state_r == ST_WRITE) || (state_r == ST_SETTLE)) ? data_r : {WIDTH{1'b0}};
  assign rd_valid = (state_r == ST_RESPOND);
  assign rd_data  = (state_r == ST_RESPOND) ? q_in : {WIDTH{1'b0}};
  assign rd_id    = (state_r == ST_RESPOND) ? id_r : {IW{1'b0}};
  assign err      = (state_r == ST_RESPOND) && (q_in != data_r);
  assign busy     = (state_r != ST_IDLE);

  // Next-state decode for the four-phase write/readback sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE:   state_nxt_s = ST_SETTLE;
      ST_SETTLE:  state_nxt_s = ST_RESPOND;
      ST_RESPOND: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transaction data, owner and round-robin pointer; ptr resets to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_r <= {WIDTH{1'b0}};
      id_r   <= {IW{1'b0}};
      ptr_r  <= IW'(N_REQ - 1);
    end else begin
      if (accept_s) begin
        data_r <= req_data[pick_idx_s*WIDTH +: WIDTH];
        id_r   <= pick_idx_s;
      end
      if (state_r == ST_RESPOND) begin
        ptr_r <= id_r;
      end
    end
  end

`ifdef REG_SHARE_LOCK_EN
  // Lock flag: sampled from the winner at accept, cleared by any IDLE cycle without an accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      lock_r <= accept_s ? req_lock[pick_idx_s] : 1'b0;
    end
  end
`endif

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit bank of `d_ff` storage registers between N_REQ requesters. It accepts one write request at a time, drives the bank's data and capture enable, then reads the captured value back. It returns the captured value to the winning requester and flags any write/readback mismatch. It sits between requester logic and the `d_ff` bank; the bank itself is external.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..16
- WIDTH, 8: width of the shared register bank

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- req_valid  in  N_REQ  per-requester write request
- req_data  in  N_REQ*WIDTH  per-requester write data; slice i is bits [i*WIDTH +: WIDTH]
- req_lock  in  N_REQ  per-requester lock request; present only with REG_SHARE_LOCK_EN
- req_ready  out  N_REQ  one-hot accept strobe
- d_out  out  WIDTH  data to the bank's d_in
- d_we  out  1  capture enable to the bank
- q_in  in  WIDTH  bank q_out
- rd_data  out  WIDTH  readback value
- rd_valid  out  1  readback strobe
- rd_id  out  $clog2(N_REQ)  requester index for rd_data
- err  out  1  readback mismatch strobe
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE → WRITE → SETTLE → RESPOND → IDLE.
- IDLE:
  - Arbitration is combinational round-robin, searching from ptr+1 upward and wrapping at N_REQ-1.
  - If any req_valid is high, req_ready[win] = 1 in the same cycle.
  - At the clock edge: latch req_data slice win into data_q, latch win into id_q, go to WRITE.
  - With no requests, stay in IDLE and hold all outputs at 0.
- WRITE: d_we = 1 and d_out = data_q for exactly one cycle.
- SETTLE: d_we = 0; d_out holds data_q. The bank has captured the data; q_in is now stable.
- RESPOND:
  - rd_valid = 1, rd_data = q_in, rd_id = id_q.
  - err = 1 if q_in != data_q.
  - ptr ← id_q.
  - Next state is IDLE.
- Handshake:
  - A requester holds req_valid and its req_data stable until it sees req_ready.
  - req_ready is never high outside IDLE.
  - Requests deasserted before acceptance are dropped without effect.
- Fairness: every requester holding req_valid is served within N_REQ transactions.
- Simultaneous events: if a new request and RESPOND coincide, the request waits until the next IDLE cycle. A requester may re-request in the cycle after its own RESPOND.
- Reset:
  - Applies to every state, including mid-transaction.
  - The next edge with rst = 0 forces IDLE, ptr = N_REQ-1 (so requester 0 wins first), and data_q = 0, id_q = 0.
  - All outputs go to 0.
  - An interrupted transaction produces no rd_valid and no err.

## Timing
- Request accepted in cycle T (req_ready high): d_we high in T+1, rd_valid/err high in T+3.
- Next accept possible in T+4, giving a maximum throughput of one transaction per 4 cycles.
- req_ready is combinational from req_valid and ptr. All other outputs are registered or decoded from state.
- rd_valid, err and d_we are single-cycle pulses.
- Outputs after reset: req_ready = 0, d_out = 0, d_we = 0, rd_data = 0, rd_valid = 0, rd_id = 0, err = 0, busy = 0.

## Configuration
- REG_SHARE_LOCK_EN, defined:
  - req_lock[win] is sampled at accept.
  - If it was set, the next IDLE grants only id_q, and only while that requester holds req_valid and req_lock. Other requesters are blocked and ptr does not advance.
  - Lock ends when req_lock[id_q] is low or req_valid[id_q] is low in IDLE; normal round-robin then resumes from ptr.
- REG_SHARE_LOCK_EN, not defined: the req_lock port and the lock logic are absent; arbitration is pure round-robin.

## Structure
- The shared package `reg_share_pkg` holds:
  - the state enum type `reg_share_state_t`;
  - localparam defaults `REG_SHARE_N_REQ_DEF = 4` and `REG_SHARE_WIDTH_DEF = 8`.
- One sub-module, `rr_pick`: purely combinational. Inputs are the request vector and ptr; outputs are the one-hot grant and the binary index. This keeps the FSM free of search logic.

## Test plan
- Single request: req_valid = 4'b0100, slice 2 = 8'hA5 → req_ready = 4'b0100 at T, d_we/d_out = 8'hA5 at T+1, rd_valid with rd_data = 8'hA5, rd_id = 2, err = 0 at T+3.
- All four requesting continuously after reset → grant order 0, 1, 2, 3, 0, with accepts 4 cycles apart.
- Mismatch: the bank model forces q_in = 8'h00 after writing 8'h3C → err = 1 and rd_data = 8'h00 at T+3.
- Reset mid-transaction: rst = 0 during SETTLE → next cycle busy = 0, no rd_valid, and the next grant goes to requester 0.
- Back-to-back same requester: requester 1 re-asserts in the cycle after RESPOND while requester 3 is waiting → requester 3 granted next.
- With REG_SHARE_LOCK_EN: requester 0 holds lock with req_valid = 4'b1111 → three consecutive grants to requester 0. Lock dropped → requester 1 granted next.
